// File: rtl/inst_fetch_controller.sv
// inst_fetch_controller
//   Drives the program counter into a combinational instruction memory and
//   registers each fetched word, with its address, into a one-entry output slot
//   that decode drains through a valid/ready handshake. A taken branch or jump
//   flushes the slot and restarts fetch at the target. Capturing HALT_WORD
//   parks the PC until the next redirect or reset.
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   imem_addr       instruction memory byte address (the pc register)
//   imem_data       instruction word for imem_addr, combinational
//   redirect_valid  branch/jump taken this cycle
//   redirect_target new PC, bits [1:0] ignored
//   out_valid       output slot holds an instruction
//   out_ready       decode accepts the slot this cycle
//   out_instr       instruction in the slot
//   out_pc          address the slot instruction was fetched from
//   halted          fetch is parked on a halt word
//   fetch_count     instructions captured since reset, saturating
module inst_fetch_controller #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           PC_STEP     = 4,
  parameter logic [31:0]           HALT_WORD   = 32'h0000_000C,
  parameter int unsigned           COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam int unsigned INSTR_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  state_t                 state_q,       state_d;
  logic [ADDR_WIDTH-1:0]  pc_q,          pc_d;
  logic                   out_valid_q,   out_valid_d;
  logic [INSTR_WIDTH-1:0] out_instr_q,   out_instr_d;
  logic [ADDR_WIDTH-1:0]  out_pc_q,      out_pc_d;
  logic                   halted_q,      halted_d;
  logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;

  logic slot_free_c;
  logic capture_c;
  logic halt_word_c;
  logic count_sat_c;

  // Targets are word aligned; the two low bits are dropped on purpose.
  logic [1:0] unused_target_lsbs;
  assign unused_target_lsbs = redirect_target[1:0];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state and slot update: redirect beats capture beats hold.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    // The slot can take a new word if it is empty or being drained now.
    slot_free_c = !out_valid_q || out_ready;
    capture_c   = (state_q == ST_FETCH) && slot_free_c && !redirect_valid;
    halt_word_c = (imem_data == HALT_WORD);
    count_sat_c = &fetch_count_q;

    if (redirect_valid) begin
      // Flush regardless of out_ready; a concurrent handshake still counts
      // as consumed by decode, so nothing is lost or duplicated.
      pc_d        = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = ST_FETCH;
    end else if (capture_c) begin
      out_instr_d = imem_data;
      out_pc_d    = pc_q;
      out_valid_d = 1'b1;
      if (!count_sat_c) begin
        fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
      end
      if (halt_word_c) begin
        // Park on the halt word so imem_addr keeps pointing at it.
        state_d = ST_HALT;
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it (halted).
      out_valid_d = 1'b0;
    end

    halted_d = (state_d == ST_HALT);
  end

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
